apb_requester: RTL



---
 rtl/apb_pkg.sv | 15 +
 rtl/apb_wait_timer.sv | 36 +++
 rtl/apb_requester.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/apb_pkg.sv
// Shared APB definitions used by the requester, the companion completer and the UVM agent.
package apb_pkg;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} apb_req_state_e;

  // PPROT bit positions and single-bit masks
  localparam int PPROT_PRIV_BIT   = 0;
  localparam int PPROT_NONSEC_BIT = 1;
  localparam int PPROT_INSTR_BIT  = 2;

  localparam logic [2:0] PPROT_PRIVILEGED  = 3'b001;
  localparam logic [2:0] PPROT_NONSECURE   = 3'b010;
  localparam logic [2:0] PPROT_INSTRUCTION = 3'b100;

endpackage

// File: rtl/apb_wait_timer.sv
// Counts consecutive PREADY=0 ACCESS cycles; expired flags the cycle that reaches TIMEOUT.
module apb_wait_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic PCLK,
  input  logic PRESETn,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  logic [CW-1:0] count;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CW'(1);
    end
  end

  // expired is asserted while the TIMEOUT-th waiting cycle is being sampled
  generate
    if (TIMEOUT == 0) begin : g_disabled
      assign expired = 1'b0;
    end else begin : g_enabled
      localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
      assign expired = enable && (count == LAST);
    end
  endgenerate

endmodule

// File: rtl/apb_requester.sv
// APB4 requester: turns a valid/ready command stream into SETUP/ACCESS transfers
// and returns a registered response stream, with an optional wait-state timeout.
module apb_requester
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                    PCLK,
  input  logic                    PRESETn,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic                    cmd_write,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_strb,
  input  logic [2:0]              cmd_prot,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic                    rsp_timeout,
  output logic [ADDR_WIDTH-1:0]   PADDR,
  output logic [2:0]              PPROT,
  output logic                    PSEL,
  output logic                    PENABLE,
  output logic                    PWRITE,
  output logic [DATA_WIDTH-1:0]   PWDATA,
  output logic [DATA_WIDTH/8-1:0] PSTRB,
  input  logic                    PREADY,
  input  logic                    PSLVERR,
  input  logic [DATA_WIDTH-1:0]   PRDATA
);

  localparam int SW = DATA_WIDTH / 8;

  apb_req_state_e state, state_d;

  logic                  ready_en;
  logic                  accept;
  logic                  timer_expired;
  logic                  psel_d, penable_d, pwrite_d;
  logic [ADDR_WIDTH-1:0] paddr_d;
  logic [2:0]            pprot_d;
  logic [DATA_WIDTH-1:0] pwdata_d;
  logic [SW-1:0]         pstrb_d;
  logic                  rsp_valid_d, rsp_err_d, rsp_timeout_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_d;

  // ready_en keeps cmd_ready low during reset and until the first edge after release
  assign cmd_ready = ready_en && ((state == IDLE) || ((state == RESP) && rsp_ready));
  assign accept    = cmd_valid && cmd_ready;

  apb_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .clear   (state == SETUP),
    .enable  ((state == ACCESS) && !PREADY),
    .expired (timer_expired)
  );

  always_comb begin
    state_d       = state;
    psel_d        = PSEL;
    penable_d     = PENABLE;
    pwrite_d      = PWRITE;
    paddr_d       = PADDR;
    pprot_d       = PPROT;
    pwdata_d      = PWDATA;
    pstrb_d       = PSTRB;
    rsp_valid_d   = rsp_valid;
    rsp_rdata_d   = rsp_rdata;
    rsp_err_d     = rsp_err;
    rsp_timeout_d = rsp_timeout;

    case (state)
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
      end
      ACCESS: begin
        // PREADY wins over a timeout expiring on the same edge
        if (PREADY) begin
          state_d       = RESP;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = PWRITE ? '0 : PRDATA;
          rsp_err_d     = PSLVERR;
          rsp_timeout_d = 1'b0;
        end else if (timer_expired) begin
          state_d       = RESP;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = '0;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: ;
    endcase

    // Acceptance happens from IDLE or from a consumed RESP; both launch SETUP
    if (accept) begin
      state_d   = SETUP;
      psel_d    = 1'b1;
      penable_d = 1'b0;
      paddr_d   = cmd_addr;
      pwrite_d  = cmd_write;
      pprot_d   = cmd_prot;
      pstrb_d   = cmd_write ? cmd_strb : '0;
      pwdata_d  = cmd_write ? cmd_wdata : PWDATA;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state       <= IDLE;
      ready_en    <= 1'b0;
      PSEL        <= 1'b0;
      PENABLE     <= 1'b0;
      PWRITE      <= 1'b0;
      PADDR       <= '0;
      PPROT       <= '0;
      PWDATA      <= '0;
      PSTRB       <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      state       <= state_d;
      ready_en    <= 1'b1;
      PSEL        <= psel_d;
      PENABLE     <= penable_d;
      PWRITE      <= pwrite_d;
      PADDR       <= paddr_d;
      PPROT       <= pprot_d;
      PWDATA      <= pwdata_d;
      PSTRB       <= pstrb_d;
      rsp_valid   <= rsp_valid_d;
      rsp_rdata   <= rsp_rdata_d;
      rsp_err     <= rsp_err_d;
      rsp_timeout <= rsp_timeout_d;
    end
  end

endmodule
